// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave latching WIDTH-bit frames onto leds and echoing the previous word on MISO; define SPI_LSB_FIRST_EN for LSB-first.
module spi_slave #(
    parameter int WIDTH = 4
) (
    input  logic             MOSI,
    input  logic             CS,
    input  logic             sclk,
    input  logic             rst,
    output logic             MISO,
    output logic [WIDTH-1:0] leds
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    logic [WIDTH-1:0] rx_shift, tx_shift, rx_next, tx_next;
    logic [CW-1:0] bit_cnt;
    logic last;
`ifdef SPI_LSB_FIRST_EN
    assign rx_next = {MOSI, rx_shift[WIDTH-1:1]};
    assign tx_next = {1'b0, tx_shift[WIDTH-1:1]};
    assign MISO = CS ? 1'b0 : tx_shift[0];
`else
    assign rx_next = {rx_shift[WIDTH-2:0], MOSI};
    assign tx_next = {tx_shift[WIDTH-2:0], 1'b0};
    assign MISO = CS ? 1'b0 : tx_shift[WIDTH-1];
`endif
    assign last = bit_cnt == CW'(WIDTH - 1);
    // A completed word is echoed straight back so back-to-back frames return it
    always_ff @(posedge sclk) begin
        if (!rst) begin
            leds     <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
        end else if (CS) begin
            bit_cnt  <= '0;
            tx_shift <= leds;
        end else begin
            rx_shift <= rx_next;
            tx_shift <= last ? rx_next : tx_next;
            leds     <= last ? rx_next : leds;
            bit_cnt  <= last ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed plus random frames checked against a frame-level model of the SPI slave.
module tb_spi_slave;
    localparam int WIDTH = 4;
    logic MOSI, CS, sclk, rst, MISO;
    logic [WIDTH-1:0] leds;
    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] m_leds = '0, m_echo = '0, m_acc = '0;
    int m_n = 0;
    bit started = 0;

    spi_slave #(.WIDTH(WIDTH)) dut (
        .MOSI(MOSI), .CS(CS), .sclk(sclk), .rst(rst), .MISO(MISO), .leds(leds)
    );

    initial sclk = 0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic exp_miso(input logic c);
        logic [WIDTH-1:0] e;
        e = m_echo;
`ifdef SPI_LSB_FIRST_EN
        return c ? 1'b0 : e[m_n];
`else
        return c ? 1'b0 : e[WIDTH-1-m_n];
`endif
    endfunction

    task automatic step(input logic m, input logic c, input logic r);
        @(negedge sclk);
        MOSI = m;
        CS = c;
        rst = r;
        #1;
        if (started) chk("miso", WIDTH'(MISO), WIDTH'(exp_miso(c)));
        @(posedge sclk);
        if (!r) begin
            m_leds = '0; m_echo = '0; m_acc = '0; m_n = 0;
        end else if (c) begin
            m_n = 0; m_acc = '0; m_echo = m_leds;
        end else begin
`ifdef SPI_LSB_FIRST_EN
            m_acc = m_acc | (WIDTH'(m) << m_n);
`else
            m_acc = WIDTH'((m_acc << 1) | WIDTH'(m));
`endif
            m_n++;
            if (m_n == WIDTH) begin
                m_leds = m_acc; m_echo = m_acc; m_acc = '0; m_n = 0;
            end
        end
        #1;
        started = 1;
        chk("leds", leds, m_leds);
    endtask

    task automatic frame(input logic [WIDTH-1:0] bits);
        for (int i = WIDTH - 1; i >= 0; i--) step(bits[i], 1'b0, 1'b1);
    endtask

    initial begin
        MOSI = 0; CS = 1; rst = 0;
        for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b0);
        chk("reset_leds", leds, 4'b0000);
        chk("reset_miso", WIDTH'(MISO), 4'b0000);
        frame(4'b1011);
`ifndef SPI_LSB_FIRST_EN
        chk("single_frame", leds, 4'b1011);
`endif
        step(1'b0, 1'b1, 1'b1);
        frame(4'b0110);
`ifndef SPI_LSB_FIRST_EN
        chk("echo_frame", leds, 4'b0110);
`endif
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("abort_keep", leds, m_leds);
        frame(4'b0011);
`ifndef SPI_LSB_FIRST_EN
        chk("after_abort", leds, 4'b0011);
`endif
        frame(4'b1111);
        frame(4'b0101);
`ifndef SPI_LSB_FIRST_EN
        chk("back_to_back", leds, 4'b0101);
`endif
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("reset_mid", leds, 4'b0000);
        frame(4'b1101);
`ifdef SPI_LSB_FIRST_EN
        chk("lsb_first", leds, 4'b1011);
`else
        chk("msb_first", leds, 4'b1101);
`endif
        for (int i = 0; i < 400; i++)
            step(1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 59) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
